// File: rtl/sumador_pkg.sv
// Shared types and helpers for the serial adder/subtractor.
// Holds the FSM state type and the step-counter width calculation.
package sumador_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_t;

    // Counter must index N = width/digit steps; a single step still needs one bit.
    function automatic int cnt_width(input int width, input int digit);
        int n;
        n = width / digit;
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/full_adder_1b.sv
// One-bit full-adder cell, the building block of the per-cycle ripple chain.
module full_adder_1b (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);

    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));

endmodule

// File: rtl/sumador_serie.sv
// Serial adder/subtractor: processes DIGIT bits per clock, LSB digit first,
// with a registered carry between digits and a start/busy/done handshake.
module sumador_serie
    import sumador_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);

    localparam int N  = WIDTH / DIGIT;
    localparam int CW = cnt_width(WIDTH, DIGIT);

    generate
        if (WIDTH < 2 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
            $error("sumador_serie: WIDTH must be >= 2 and a multiple of DIGIT");
        end
    endgenerate

    state_t           state;
    state_t           state_nxt;
    logic             load;
    logic             step;
    logic             last;

    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             carry;
    logic [CW-1:0]    cnt;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] acc_nxt;

    logic [DIGIT:0]   chain;
    logic [DIGIT-1:0] dig;

    assign last = (cnt == CW'(N - 1));

    // Ripple chain over the low DIGIT bits of the working operands.
    assign chain[0] = carry;
    generate
        for (genvar i = 0; i < DIGIT; i++) begin : g_cell
            full_adder_1b u_fa (
                .a  (op_a[i]),
                .b  (op_b[i]),
                .ci (chain[i]),
                .s  (dig[i]),
                .co (chain[i+1])
            );
        end
    endgenerate

    // The new digit enters at the top so that after N steps the LSB digit sits at bit 0.
    generate
        if (DIGIT == WIDTH) begin : g_acc_full
            assign acc_nxt = dig;
        end else begin : g_acc_shift
            assign acc_nxt = {dig, acc[WIDTH-1:DIGIT]};
        end
    endgenerate

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = RUN;
            RUN:     if (last)  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        load = 1'b0;
        step = 1'b0;
        busy = 1'b0;
        case (state)
            IDLE: load = start;
            RUN: begin
                step = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            acc   <= '0;
            done  <= 1'b0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            done <= 1'b0;
            if (load) begin
                op_a  <= a;
                op_b  <= sub ? ~b : b;
                carry <= sub ? 1'b1 : cin;
                cnt   <= '0;
                acc   <= '0;
            end else if (step) begin
                op_a  <= op_a >> DIGIT;
                op_b  <= op_b >> DIGIT;
                acc   <= acc_nxt;
                carry <= chain[DIGIT];
                cnt   <= cnt + CW'(1);
                // Outputs live in their own register so partial digits never show.
                if (last) begin
                    sum  <= acc_nxt;
                    cout <= chain[DIGIT];
                    ovf  <= chain[DIGIT] ^ chain[DIGIT-1];
                    done <= 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_sumador_serie.sv
// Scoreboard bench for sumador_serie: one DIGIT=1 and one DIGIT=4 instance,
// directed cases plus random operands checked against an arithmetic model.
module tb_sumador_serie;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       start1 = 1'b0;
    logic       start2 = 1'b0;
    logic       cin    = 1'b0;
    logic       sub    = 1'b0;
    logic [7:0] a      = '0;
    logic [7:0] b      = '0;

    logic       busy1, done1, cout1, ovf1;
    logic [7:0] sum1;
    logic       busy2, done2, cout2, ovf2;
    logic [7:0] sum2;

    int vectors     = 0;
    int miscompares = 0;
    int cyc         = 0;

    typedef struct {
        logic [7:0] sum;
        logic       cout;
        logic       ovf;
        int         due;
    } exp_t;

    exp_t q1[$];
    exp_t q2[$];

    sumador_serie #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy1), .done(done1), .sum(sum1), .cout(cout1), .ovf(ovf1)
    );

    sumador_serie #(.WIDTH(8), .DIGIT(4)) dut2 (
        .clk(clk), .rst_n(rst_n), .start(start2), .a(a), .b(b), .cin(cin), .sub(sub),
        .busy(busy2), .done(done2), .sum(sum2), .cout(cout2), .ovf(ovf2)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    function automatic exp_t mk(input logic [7:0] s, input logic c, input logic o);
        exp_t e;
        e.sum  = s;
        e.cout = c;
        e.ovf  = o;
        e.due  = 0;
        return e;
    endfunction

    // Reference: plain integer addition; overflow from operand/result signs.
    function automatic exp_t model(input logic [7:0] ia, input logic [7:0] ib,
                                   input logic icin, input logic isub);
        exp_t        e;
        logic [7:0]  bo;
        int unsigned total;
        bo     = isub ? ~ib : ib;
        total  = 32'(ia) + 32'(bo) + (isub ? 32'd1 : 32'(icin));
        e.sum  = total[7:0];
        e.cout = (total > 255);
        e.ovf  = (ia[7] == bo[7]) && (e.sum[7] != ia[7]);
        e.due  = 0;
        return e;
    endfunction

    always @(negedge clk) begin
        if (done1 === 1'b1) begin
            if (q1.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut1 spurious done: sum 0x%0h with nothing pending (cycle %0d)", sum1, cyc);
            end else begin
                exp_t e;
                e = q1.pop_front();
                check("dut1 sum", 32'(sum1), 32'(e.sum));
                check("dut1 cout", 32'(cout1), 32'(e.cout));
                check("dut1 ovf", 32'(ovf1), 32'(e.ovf));
                check("dut1 latency", cyc, e.due);
            end
        end
    end

    always @(negedge clk) begin
        if (done2 === 1'b1) begin
            if (q2.size() == 0) begin
                vectors++;
                miscompares++;
                $display("FAIL dut2 spurious done: sum 0x%0h with nothing pending (cycle %0d)", sum2, cyc);
            end else begin
                exp_t e;
                e = q2.pop_front();
                check("dut2 sum", 32'(sum2), 32'(e.sum));
                check("dut2 cout", 32'(cout2), 32'(e.cout));
                check("dut2 ovf", 32'(ovf2), 32'(e.ovf));
                check("dut2 latency", cyc, e.due);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input int inst);
        int n = 0;
        while (((inst == 1) ? busy1 : busy2) && n < 100) begin
            tick(1);
            n++;
        end
        if ((inst == 1) ? busy1 : busy2) begin
            vectors++;
            miscompares++;
            $display("FAIL dut%0d idle timeout: busy still high after %0d cycles", inst, n);
        end
    endtask

    // Called #1 after an edge; the start pulse is accepted on the next edge.
    task automatic issue(input int inst, input logic [7:0] ia, input logic [7:0] ib,
                         input logic icin, input logic isub, input exp_t e);
        wait_idle(inst);
        a   = ia;
        b   = ib;
        cin = icin;
        sub = isub;
        if (inst == 1) start1 = 1'b1;
        else           start2 = 1'b1;
        tick(1);
        start1 = 1'b0;
        start2 = 1'b0;
        e.due  = cyc + ((inst == 1) ? 8 : 2);
        if (inst == 1) q1.push_back(e);
        else           q2.push_back(e);
    endtask

    initial begin
        logic [7:0] ra, rb;
        logic       rc, rs;
        int         n;

        // Reset held for two edges.
        rst_n = 1'b0;
        tick(2);
        check("rst busy1", 32'(busy1), 0);
        check("rst done1", 32'(done1), 0);
        check("rst sum1", 32'(sum1), 0);
        check("rst cout1", 32'(cout1), 0);
        check("rst ovf1", 32'(ovf1), 0);
        check("rst busy2", 32'(busy2), 0);
        check("rst sum2", 32'(sum2), 0);
        rst_n = 1'b1;
        tick(5);

        // Directed cases with hand-derived results.
        issue(1, 8'h5A, 8'h33, 1'b1, 1'b0, mk(8'h8E, 1'b0, 1'b1));
        issue(1, 8'hFF, 8'h01, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b0));
        issue(1, 8'h80, 8'h80, 1'b0, 1'b0, mk(8'h00, 1'b1, 1'b1));
        issue(1, 8'h10, 8'h20, 1'b1, 1'b1, mk(8'hF0, 1'b0, 1'b0));
        issue(1, 8'h20, 8'h10, 1'b0, 1'b1, mk(8'h10, 1'b1, 1'b0));

        // A start during RUN with different operands must be ignored.
        issue(1, 8'h12, 8'h34, 1'b0, 1'b0, mk(8'h46, 1'b0, 1'b0));
        tick(2);
        a      = 8'hFF;
        b      = 8'hFF;
        sub    = 1'b1;
        start1 = 1'b1;
        tick(1);
        start1 = 1'b0;
        wait_idle(1);
        tick(2);
        check("dut1 ignored start stays idle", 32'(busy1), 0);

        // Reset in the middle of an operation aborts it silently.
        issue(1, 8'h5A, 8'h33, 1'b1, 1'b0, mk(8'h8E, 1'b0, 1'b1));
        tick(4);
        rst_n = 1'b0;
        q1.delete();
        tick(1);
        check("abort busy1", 32'(busy1), 0);
        check("abort done1", 32'(done1), 0);
        check("abort sum1", 32'(sum1), 0);
        check("abort cout1", 32'(cout1), 0);
        rst_n = 1'b1;
        tick(10);
        check("abort stays idle", 32'(busy1), 0);

        // DIGIT=4: overflow case, then back-to-back start on the done cycle.
        issue(2, 8'h7F, 8'h01, 1'b0, 1'b0, mk(8'h80, 1'b0, 1'b1));
        issue(2, 8'h01, 8'h02, 1'b0, 1'b0, mk(8'h03, 1'b0, 1'b0));

        // Random operands against the arithmetic model.
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            issue(1, ra, rb, rc, rs, model(ra, rb, rc, rs));
            if ($urandom_range(0, 3) == 0) tick(9);
        end
        for (int i = 0; i < 40; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom_range(0, 1));
            rs = 1'($urandom_range(0, 1));
            issue(2, ra, rb, rc, rs, model(ra, rb, rc, rs));
            if ($urandom_range(0, 3) == 0) tick($urandom_range(1, 3));
        end

        n = 0;
        while ((q1.size() != 0 || q2.size() != 0) && n < 100) begin
            tick(1);
            n++;
        end
        check("dut1 results drained", 32'(q1.size()), 0);
        check("dut2 results drained", 32'(q2.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

endmodule
